// File: rtl/alu8_arbiter.sv
// alu8_arbiter: round-robin arbiter/sequencer sharing one signed add/sub
// datapath between two requesters.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   reqN/opN/ciN/xN/yN  requester N request and operands (N = 0, 1)
//   gntN                one-cycle combinational grant; operands captured then
//   dp_op/ci/x/y        registered operands driven to the shared datapath
//   dp_r, dp_of         datapath result and signed overflow (combinational)
//   rsp_valid/ready     response handshake
//   rsp_id/r/of         registered response: owner id, result, overflow
//   busy                high whenever the sequencer is not idle
//
// Build option: define ALU8_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins ties, no last-winner pointer). Default is round-robin.
module alu8_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             op0,
   input  logic             ci0,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   output logic             gnt0,
   input  logic             req1,
   input  logic             op1,
   input  logic             ci1,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] y1,
   output logic             gnt1,
   output logic             dp_op,
   output logic             dp_ci,
   output logic [WIDTH-1:0] dp_x,
   output logic [WIDTH-1:0] dp_y,
   input  logic [WIDTH-1:0] dp_r,
   input  logic             dp_of,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_r,
   output logic             rsp_of,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic             op;
      logic             ci;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
   } opnd_t;

   state_e           state_q, state_d;
   opnd_t            opnd_q, opnd_d;
   logic             owner_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_r_q;
   logic             rsp_of_q;
   logic             winner_c;
   logic             grant_ok_c;
   logic             grant_c;

`ifndef ALU8_ARB_FIXED_PRIO_EN
   logic             last_q;
`endif

   // Tie-break: the requester that did not win last time (or 0 when fixed).
   always_comb begin
      winner_c = req1;
      if (req0 && req1) begin
`ifdef ALU8_ARB_FIXED_PRIO_EN
         winner_c = 1'b0;
`else
         winner_c = ~last_q;
`endif
      end
   end

   // A grant may issue when idle or while the pending response is consumed.
   // rst gates it so grants drop immediately on an asynchronous reset.
   assign grant_ok_c = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
   assign grant_c    = grant_ok_c && (req0 || req1);
   assign opnd_d     = winner_c ? opnd_t'{op1, ci1, x1, y1} : opnd_t'{op0, ci0, x0, y0};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_c) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = grant_c ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state and the Mealy grant.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      busy = 1'b0;
      if (grant_c) begin
         gnt0 = ~winner_c;
         gnt1 = winner_c;
      end
      if (state_q != IDLE) busy = 1'b1;
   end

   // Operand capture on grant; result capture at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd_q      <= '0;
         owner_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_r_q     <= '0;
         rsp_of_q    <= 1'b0;
`ifndef ALU8_ARB_FIXED_PRIO_EN
         last_q      <= 1'b1;
`endif
      end else begin
         if (grant_c) begin
            opnd_q  <= opnd_d;
            owner_q <= winner_c;
`ifndef ALU8_ARB_FIXED_PRIO_EN
            last_q  <= winner_c;
`endif
         end
         if (state_q == EXEC) begin
            rsp_r_q     <= dp_r;
            rsp_of_q    <= dp_of;
            rsp_id_q    <= owner_q;
            rsp_valid_q <= 1'b1;
         end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign dp_op     = opnd_q.op;
   assign dp_ci     = opnd_q.ci;
   assign dp_x      = opnd_q.x;
   assign dp_y      = opnd_q.y;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_r     = rsp_r_q;
   assign rsp_of    = rsp_of_q;

endmodule

// File: doc/alu8_arbiter.md
Name: alu8_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit signed add/subtract datapath (r = x + y + ci, or r = x - y - ci when op=1, with overflow flag) between two requesters.
- Captures the winning requester's operands, drives the shared datapath from registers, samples its result and overflow, and returns them on a single response channel tagged with the requester id.
- Sits between two client sequencers and the single add/sub datapath instance.

Parameters:
WIDTH, 8, operand/result width; must equal the attached datapath width.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 request; held with operands until gnt0
op0  input  1  requester 0 operation: 0 add, 1 subtract
ci0  input  1  requester 0 carry/borrow in
x0  input  WIDTH  requester 0 operand x (signed)
y0  input  WIDTH  requester 0 operand y (signed)
gnt0  output  1  one-cycle grant; operands captured this cycle
req1, op1, ci1, x1, y1, gnt1  (as above, requester 1)
dp_op  output  1  to datapath op
dp_ci  output  1  to datapath ci
dp_x  output  WIDTH  to datapath x
dp_y  output  WIDTH  to datapath y
dp_r  input  WIDTH  datapath result (combinational from dp_*)
dp_of  input  1  datapath signed overflow
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  1  requester id of response
rsp_r  output  WIDTH  registered result
rsp_of  output  1  registered overflow
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; operand regs, dp_*, rsp_r, rsp_of, rsp_id, rsp_valid all 0; gnt0/gnt1 0; round-robin last-winner pointer=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- Grant cycle: permitted in IDLE, or in RESP when rsp_ready=1.
  - If any req is high: winner = the only requester, or on a tie the one not equal to last-winner.
  - gnt<winner>=1 combinationally (Mealy) that cycle.
  - On the clock edge: capture op/ci/x/y into operand regs, owner<=winner, last-winner<=winner, next state EXEC.
  - Never both gnt high at once.
- IDLE with no req: remain IDLE; gnt0=gnt1=0.
- EXEC (exactly one cycle):
  - dp_* come straight from operand regs.
  - Edge: rsp_r<=dp_r, rsp_of<=dp_of, rsp_id<=owner, rsp_valid<=1, next state RESP.
- RESP:
  - rsp_valid=1; rsp_r/rsp_of/rsp_id held stable while rsp_ready=0.
  - On rsp_ready=1: the response is consumed. If a grant occurs the same cycle, go to EXEC (rsp_valid falls); otherwise go to IDLE with rsp_valid=0.
- Latency and throughput: gnt at cycle T, rsp_valid at T+2. Back-to-back sustained rate is one op per 2 cycles with rsp_ready=1.
- dp_* hold the last operands when idle; they change only on a grant edge.
- A req deasserted before its grant is legal and is dropped silently. Operands must be stable only in the grant cycle.
- Arithmetic is performed entirely by the datapath; the block adds no width extension or saturation. rsp_of is the datapath's signed overflow, unchanged.
- Reset mid-operation (EXEC or RESP): in-flight op is discarded, no response is issued, and state returns to IDLE.

Optional Feature:
- Macro ALU8_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins ties. The last-winner pointer is not implemented.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset: assert rst mid-cycle -> rsp_valid, gnt0, gnt1, busy, dp_x, rsp_r = 0 immediately, with no clock edge required.
- req0 only, op0=0, ci0=0, x0=0x05, y0=0x03, rsp_ready=1 -> gnt0 at T; rsp_valid at T+2 with rsp_id=0, rsp_r=0x08, rsp_of=0.
- req1 only, op1=1, ci1=0, x1=0x80, y1=0x01 -> rsp_id=1, rsp_r=0x7F, rsp_of=1; with op1=0, ci1=1, x1=0x7F, y1=0x00 -> rsp_r=0x80, rsp_of=1.
- req0 and req1 both held for 4 ops, rsp_ready=1 -> grant order 0,1,0,1 every 2 cycles, each response id matching its grant. With ALU8_ARB_FIXED_PRIO_EN defined -> order 0,0,0,0.
- Response in RESP, rsp_ready=0 for 3 cycles with both reqs high -> rsp_* stable and no gnt. When rsp_ready=1 -> grant in that same cycle, rsp_valid low on the next cycle.
- rst pulsed while in EXEC -> no rsp_valid for that op. After release, a tie -> gnt0 first.
